// File: rtl/spi_x1_arb_if.sv
// rtl/spi_x1_arb_if.sv - requester, result and x1 engine signals of spi_x1_arb
// slave: arbiter side; master: requesters plus engine side.
interface spi_x1_arb_if;
  logic        r0_req, r1_req;
  logic [7:0]  r0_cmd, r1_cmd;
  logic [23:0] r0_addr, r1_addr;
  logic [2:0]  r0_dummy, r1_dummy;
  logic [7:0]  r0_len, r1_len;
  logic        r0_gnt, r1_gnt;
  logic [7:0]  rd_data;
  logic        r0_rvalid, r1_rvalid;
  logic        r0_done, r1_done;
  logic        err;
  logic        eng_start;
  logic [7:0]  eng_cmd;
  logic [23:0] eng_addr;
  logic [2:0]  eng_dummy_num;
  logic        eng_exist_rx_data;
  logic        eng_finish;
  logic [7:0]  eng_data_in;

  modport slave (
    input  r0_req, r1_req, r0_cmd, r1_cmd, r0_addr, r1_addr,
    input  r0_dummy, r1_dummy, r0_len, r1_len, eng_finish, eng_data_in,
    output r0_gnt, r1_gnt, rd_data, r0_rvalid, r1_rvalid, r0_done, r1_done,
    output err, eng_start, eng_cmd, eng_addr, eng_dummy_num, eng_exist_rx_data
  );

  modport master (
    output r0_req, r1_req, r0_cmd, r1_cmd, r0_addr, r1_addr,
    output r0_dummy, r1_dummy, r0_len, r1_len, eng_finish, eng_data_in,
    input  r0_gnt, r1_gnt, rd_data, r0_rvalid, r1_rvalid, r0_done, r1_done,
    input  err, eng_start, eng_cmd, eng_addr, eng_dummy_num, eng_exist_rx_data
  );
endinterface

// File: rtl/spi_x1_arb.sv
// rtl/spi_x1_arb.sv - round-robin two-requester front end for an x1 SPI engine
// Optional engine-stall timeout: define SPI_ARB_TIMEOUT_EN.
module spi_x1_arb #(
  parameter int TIMEOUT_CYC = 4096
) (
  input logic         clk,
  input logic         rst_n,
  spi_x1_arb_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_RUN, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_owner, r_last;
  logic [7:0]  r_cmd, r_len, r_cnt, r_rd_data;
  logic [23:0] r_addr;
  logic [2:0]  r_dummy;
  logic        r_exist, r_rvalid;
  logic        w_pick, w_last_byte, w_timeout;
  logic        w_gnt0, w_gnt1, w_start, w_done0, w_done1;
  logic [7:0]  w_len_sel;

  // With both requesting, the side not served last wins
  assign w_pick      = (bus.r0_req && bus.r1_req) ? ~r_last : bus.r1_req;
  assign w_len_sel   = r_owner ? bus.r1_len : bus.r0_len;
  assign w_last_byte = bus.eng_finish && ((r_cnt + 8'd1) == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_start = 1'b0;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.r0_req || bus.r1_req) w_next = S_GRANT;
      S_GRANT: begin
        w_next = S_START;
        w_gnt0 = ~r_owner;
        w_gnt1 = r_owner;
      end
      S_START: begin
        w_next  = S_RUN;
        w_start = 1'b1;
      end
      S_RUN: begin
        if (w_timeout || (bus.eng_finish && (r_len == 8'd0 || w_last_byte)))
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next  = S_IDLE;
        w_done0 = ~r_owner;
        w_done1 = r_owner;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_cmd     <= 8'd0;
      r_addr    <= 24'd0;
      r_dummy   <= 3'd0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
      r_exist   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rd_data <= 8'd0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.r0_req || bus.r1_req) r_owner <= w_pick;
        S_GRANT: begin
          r_last  <= r_owner;
          r_cmd   <= r_owner ? bus.r1_cmd : bus.r0_cmd;
          r_addr  <= r_owner ? bus.r1_addr : bus.r0_addr;
          r_dummy <= r_owner ? bus.r1_dummy : bus.r0_dummy;
          r_len   <= w_len_sel;
          r_exist <= (w_len_sel != 8'd0);
        end
        S_START: r_cnt <= 8'd0;
        S_RUN: begin
          if (bus.eng_finish && r_len != 8'd0) begin
            r_rd_data <= bus.eng_data_in;
            r_rvalid  <= 1'b1;
            r_cnt     <= r_cnt + 8'd1;
            if (w_last_byte) r_exist <= 1'b0;
          end
          if (w_timeout) r_exist <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err;

  // Counts cycles since START or the latest eng_finish; START itself is cycle 0
  assign w_timeout = (r_state == S_RUN) && !bus.eng_finish && (r_tcnt == TLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == S_GRANT || (r_state == S_RUN && bus.eng_finish))
        r_tcnt <= '0;
      else if (r_state == S_START || r_state == S_RUN)
        r_tcnt <= r_tcnt + TW'(1);
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_tcyc;
  assign w_unused_tcyc = (TIMEOUT_CYC != 0);
  assign w_timeout     = 1'b0;
  assign bus.err       = 1'b0;
`endif

  assign bus.r0_gnt            = w_gnt0;
  assign bus.r1_gnt            = w_gnt1;
  assign bus.r0_done           = w_done0;
  assign bus.r1_done           = w_done1;
  assign bus.r0_rvalid         = r_rvalid && !r_owner;
  assign bus.r1_rvalid         = r_rvalid && r_owner;
  assign bus.rd_data           = r_rd_data;
  assign bus.eng_start         = w_start;
  assign bus.eng_cmd           = r_cmd;
  assign bus.eng_addr          = r_addr;
  assign bus.eng_dummy_num     = r_dummy;
  assign bus.eng_exist_rx_data = r_exist;

endmodule

// File: tb/tb_spi_x1_arb.sv
// tb/tb_spi_x1_arb.sv - directed bench for spi_x1_arb with a transaction-level reference model
module tb_spi_x1_arb;
  localparam int TOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;

  spi_x1_arb_if ifc ();

  spi_x1_arb #(.TIMEOUT_CYC(TOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: transaction view, expected outputs for the cycle after each edge
  bit          m_busy = 0, m_owner = 0, m_last = 1, m_rx = 0, m_rest = 0;
  int          m_t = 0, m_left = 0, m_quiet = 0;
  bit          x_g0 = 0, x_g1 = 0, x_v0 = 0, x_v1 = 0, x_d0 = 0, x_d1 = 0;
  bit          x_st = 0, x_err = 0, x_exist = 0;
  logic [7:0]  x_data = 0, x_cmd = 0;
  logic [23:0] x_addr = 0;
  logic [2:0]  x_dummy = 0;

  task automatic m_finish_txn();
    if (m_owner) x_d1 = 1; else x_d0 = 1;
    m_busy = 0;
    m_rest = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    {x_g0, x_g1, x_v0, x_v1, x_d0, x_d1, x_st, x_err} = '0;
    if (!rst_n) begin
      m_busy = 0; m_last = 1; m_rest = 0; m_t = 0; x_exist = 0;
      x_data = 0; x_cmd = 0; x_addr = 0; x_dummy = 0;
    end else if (!m_busy) begin
      if (m_rest) m_rest = 0;
      else if (ifc.r0_req || ifc.r1_req) begin
        m_owner = (ifc.r0_req && ifc.r1_req) ? !m_last : ifc.r1_req;
        m_busy = 1;
        m_t = 0;
        if (m_owner) x_g1 = 1; else x_g0 = 1;
      end
    end else begin
      m_t++;
      if (m_t == 1) begin
        m_last  = m_owner;
        x_st    = 1;
        x_cmd   = m_owner ? ifc.r1_cmd : ifc.r0_cmd;
        x_addr  = m_owner ? ifc.r1_addr : ifc.r0_addr;
        x_dummy = m_owner ? ifc.r1_dummy : ifc.r0_dummy;
        m_left  = m_owner ? ifc.r1_len : ifc.r0_len;
        m_rx    = (m_left != 0);
        x_exist = m_rx;
        m_quiet = 0;
      end else if (m_t == 2) begin
        m_quiet++;
      end else if (ifc.eng_finish) begin
        m_quiet = 0;
        if (!m_rx) m_finish_txn();
        else begin
          x_data = ifc.eng_data_in;
          if (m_owner) x_v1 = 1; else x_v0 = 1;
          m_left--;
          if (m_left == 0) begin
            x_exist = 0;
            m_finish_txn();
          end
        end
      end else begin
        m_quiet++;
`ifdef SPI_ARB_TIMEOUT_EN
        if (m_quiet == TOUT) begin
          x_exist = 0;
          x_err = 1;
          m_finish_txn();
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("r0_gnt", ifc.r0_gnt, x_g0);
      cmp("r1_gnt", ifc.r1_gnt, x_g1);
      cmp("r0_rvalid", ifc.r0_rvalid, x_v0);
      cmp("r1_rvalid", ifc.r1_rvalid, x_v1);
      cmp("r0_done", ifc.r0_done, x_d0);
      cmp("r1_done", ifc.r1_done, x_d1);
      cmp("err", ifc.err, x_err);
      cmp("eng_start", ifc.eng_start, x_st);
      cmp("eng_exist", ifc.eng_exist_rx_data, x_exist);
      cmp("rd_data", ifc.rd_data, x_data);
      cmp("eng_cmd", ifc.eng_cmd, x_cmd);
      cmp("eng_addr", ifc.eng_addr, x_addr);
      cmp("eng_dummy", ifc.eng_dummy_num, x_dummy);
    end
  end

  // Observation counters for the literal checks
  int         c_g0, c_g1, c_v0, c_v1, c_d0, c_d1, c_st, c_err;
  int         st_cyc, done_cyc, fall_cyc;
  bit         ex_seen, prev_ex;
  logic [7:0] st_cmd;
  logic [7:0] got[$];
  int         order[$];
  logic [7:0] rsp_q[$];

  always @(negedge clk) begin
    if (ifc.r0_gnt) begin c_g0++; order.push_back(0); end
    if (ifc.r1_gnt) begin c_g1++; order.push_back(1); end
    if (ifc.r0_rvalid) c_v0++;
    if (ifc.r1_rvalid) c_v1++;
    if (ifc.r0_rvalid || ifc.r1_rvalid) got.push_back(ifc.rd_data);
    if (ifc.r0_done) begin c_d0++; done_cyc = cyc; end
    if (ifc.r1_done) begin c_d1++; done_cyc = cyc; end
    if (ifc.err) c_err++;
    if (ifc.eng_start) begin c_st++; st_cyc = cyc; st_cmd = ifc.eng_cmd; end
    if (prev_ex && !ifc.eng_exist_rx_data) fall_cyc = cyc;
    if (ifc.eng_exist_rx_data) ex_seen = 1;
    prev_ex = ifc.eng_exist_rx_data;
  end

  task automatic clr_mon();
    {c_g0, c_g1, c_v0, c_v1, c_d0, c_d1, c_st, c_err} = '0;
    st_cyc = -1; done_cyc = -1; fall_cyc = -2;
    ex_seen = 0;
    got.delete();
    order.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit r, input logic [7:0] cmd, input logic [23:0] addr,
                         input logic [2:0] dum, input logic [7:0] len);
    if (!r) begin
      ifc.r0_cmd = cmd; ifc.r0_addr = addr; ifc.r0_dummy = dum; ifc.r0_len = len; ifc.r0_req = 1;
    end else begin
      ifc.r1_cmd = cmd; ifc.r1_addr = addr; ifc.r1_dummy = dum; ifc.r1_len = len; ifc.r1_req = 1;
    end
  endtask

  task automatic wait_gnt_drop(input bit r);
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = r ? ifc.r1_gnt : ifc.r0_gnt;
    end
    cmp("wait_gnt", ok, 1);
    tick();
    if (r) ifc.r1_req = 0; else ifc.r0_req = 0;
  endtask

  task automatic wait_start();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = ifc.eng_start;
    end
    cmp("wait_start", ok, 1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = ifc.r0_done || ifc.r1_done;
    end
    cmp("wait_done", ok, 1);
  endtask

  // Engine: one finish per byte until the arbiter drops eng_exist_rx_data
  task automatic serve();
    int k = 0;
    do begin
      tick();
      ifc.eng_finish = 1;
      ifc.eng_data_in = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'(8'h80 + k);
      tick();
      ifc.eng_finish = 0;
      k++;
    end while (ifc.eng_exist_rx_data && k < 400);
  endtask

  initial begin
    {ifc.r0_req, ifc.r1_req, ifc.eng_finish} = '0;
    {ifc.r0_cmd, ifc.r1_cmd, ifc.r0_len, ifc.r1_len, ifc.eng_data_in} = '0;
    {ifc.r0_addr, ifc.r1_addr} = '0;
    {ifc.r0_dummy, ifc.r1_dummy} = '0;
    #1 rst_n = 0;
    #1 chk_on = 1;
    cmp("rst_exist", ifc.eng_exist_rx_data, 0);
    cmp("rst_rd_data", ifc.rd_data, 0);
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();

    // finish while idle is ignored
    clr_mon();
    ifc.eng_finish = 1; ifc.eng_data_in = 8'h55;
    tick();
    ifc.eng_finish = 0;
    repeat (3) tick();
    cmp("idle_fin_rvalid", c_v0 + c_v1, 0);
    cmp("idle_fin_gnt", c_g0 + c_g1, 0);

    // r0 read-ID, three bytes
    clr_mon();
    rsp_q = '{8'hEF, 8'h40, 8'h18};
    set_req(0, 8'h9F, 24'h0, 3'd0, 8'd3);
    wait_gnt_drop(0);
    wait_start();
    serve();
    wait_done();
    tick();
    cmp("id_gnt0", c_g0, 1);
    cmp("id_gnt1", c_g1, 0);
    cmp("id_start", c_st, 1);
    cmp("id_cmd", st_cmd, 8'h9F);
    cmp("id_nbytes", got.size(), 3);
    if (got.size() == 3) begin
      cmp("id_b0", got[0], 8'hEF);
      cmp("id_b1", got[1], 8'h40);
      cmp("id_b2", got[2], 8'h18);
    end
    cmp("id_done_at_fall", done_cyc, fall_cyc);
    cmp("id_done0", c_d0, 1);

    // r1 write-enable, no receive phase
    clr_mon();
    set_req(1, 8'h06, 24'h0, 3'd0, 8'd0);
    wait_gnt_drop(1);
    wait_start();
    serve();
    wait_done();
    tick();
    cmp("wren_rvalid", c_v0 + c_v1, 0);
    cmp("wren_exist_seen", ex_seen, 0);
    cmp("wren_done1", c_d1, 1);
    cmp("wren_done0", c_d0, 0);

    // both requesting from reset, held across four transactions
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    clr_mon();
    set_req(0, 8'h03, 24'h000010, 3'd0, 8'd1);
    set_req(1, 8'h0B, 24'h000020, 3'd1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      wait_start();
      serve();
      wait_done();
    end
    tick();
    ifc.r0_req = 0; ifc.r1_req = 0;
    repeat (3) tick();
    cmp("rr_ngrants", order.size(), 4);
    if (order.size() == 4) begin
      cmp("rr_0", order[0], 0);
      cmp("rr_1", order[1], 1);
      cmp("rr_2", order[2], 0);
      cmp("rr_3", order[3], 1);
    end

    // reset after two of four bytes
    clr_mon();
    set_req(0, 8'h03, 24'h123456, 3'd0, 8'd4);
    wait_gnt_drop(0);
    wait_start();
    for (int i = 0; i < 2; i++) begin
      tick();
      ifc.eng_finish = 1; ifc.eng_data_in = 8'(8'h11 * (i + 1));
      tick();
      ifc.eng_finish = 0;
    end
    #2 rst_n = 0;
    #1;
    cmp("abort_exist", ifc.eng_exist_rx_data, 0);
    cmp("abort_rvalid", ifc.r0_rvalid, 0);
    cmp("abort_rd_data", ifc.rd_data, 0);
    repeat (3) tick();
    rst_n = 1;
    repeat (5) tick();
    cmp("abort_no_done", c_d0 + c_d1, 0);
    set_req(1, 8'h05, 24'h0, 3'd0, 8'd1);
    wait_gnt_drop(1);
    wait_start();
    serve();
    wait_done();
    tick();

    // len 255 delivers exactly 255 bytes
    clr_mon();
    set_req(1, 8'h0B, 24'h000100, 3'd1, 8'd255);
    wait_gnt_drop(1);
    wait_start();
    serve();
    wait_done();
    tick();
    cmp("l255_count", c_v1, 255);
    cmp("l255_done", c_d1, 1);
    if (got.size() == 255) cmp("l255_last", got[254], 8'h7E);

    // engine stalls after start
    clr_mon();
    set_req(0, 8'h3B, 24'h000200, 3'd2, 8'd2);
    wait_gnt_drop(0);
    wait_start();
    repeat (40) tick();
`ifdef SPI_ARB_TIMEOUT_EN
    cmp("to_err", c_err, 1);
    cmp("to_done", c_d0, 1);
    cmp("to_delay", done_cyc - st_cyc, TOUT);
`else
    cmp("stall_exist", ifc.eng_exist_rx_data, 1);
    cmp("stall_done", c_d0, 0);
    cmp("stall_err", c_err, 0);
    serve();
    wait_done();
`endif
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end
endmodule
